// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: function codes, controller states
// and the per-operation slice control word.
package alu_pkg;

  typedef enum logic [2:0] {
    FN_AND = 3'b000,
    FN_OR  = 3'b001,
    FN_ADD = 3'b010,
    FN_NOR = 3'b100,
    FN_SUB = 3'b110,
    FN_SLT = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_AND = 2'd0;
  localparam logic [1:0] SEL_OR  = 2'd1;
  localparam logic [1:0] SEL_SUM = 2'd2;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic [1:0] sel;
    logic       arith;
    logic       slt;
  } op_ctrl_t;

  // Unlisted codes fall through to AND (all-zero control word).
  function automatic op_ctrl_t decode_func(input logic [2:0] func);
    op_ctrl_t c;
    c = '0;
    c.sel = SEL_AND;
    case (func)
      FN_OR:  c.sel = SEL_OR;
      FN_ADD: begin c.sel = SEL_SUM; c.arith = 1'b1; end
      FN_SUB: begin c.sel = SEL_SUM; c.arith = 1'b1; c.binv = 1'b1; end
      FN_SLT: begin c.sel = SEL_SUM; c.arith = 1'b1; c.binv = 1'b1; c.slt = 1'b1; end
      FN_NOR: begin c.sel = SEL_AND; c.ainv = 1'b1; c.binv = 1'b1; end
      default: c.sel = SEL_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, and/or/sum select, full-adder carry.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       ainv,
  input  logic       binv,
  input  logic [1:0] sel,
  output logic       res,
  output logic       cout
);

  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa   = a ^ ainv;
    bb   = b ^ binv;
    sum  = aa ^ bb ^ cin;
    cout = (aa & bb) | (aa & cin) | (bb & cin);
    case (sel)
      SEL_OR:  res = aa | bb;
      SEL_SUM: res = sum;
      default: res = aa & bb;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: shifts operands LSB first through one slice,
// then publishes result and status with a one-cycle done pulse.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state;
  state_e           state_n;
  logic             load_c;
  logic             step_c;
  logic             finish_c;
  logic             last_c;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             carry_msb;
  op_ctrl_t         ctl;

  logic             slice_res;
  logic             slice_cout;
  logic             ovf_c;
  logic             slt_bit_c;
  logic [WIDTH-1:0] fin_res_c;

  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .ainv (ctl.ainv),
    .binv (ctl.binv),
    .sel  (ctl.sel),
    .res  (slice_res),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Abort only matters in RUN; start only in IDLE.
  always_comb begin
    state_n  = state;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    last_c   = (cnt == CW'(WIDTH - 1));
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else begin
          step_c = 1'b1;
          if (last_c) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        finish_c = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // After the last bit, carry holds the MSB carry-out and carry_msb the MSB carry-in.
  always_comb begin
    ovf_c     = carry_msb ^ carry;
    slt_bit_c = res_sh[WIDTH-1] ^ ovf_c;
    fin_res_c = ctl.slt ? WIDTH'(slt_bit_c) : res_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      ctl       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_n != ST_IDLE);
      done <= finish_c;
      if (load_c) begin
        a_sh  <= a;
        b_sh  <= b;
        cnt   <= '0;
        ctl   <= decode_func(func);
        carry <= decode_func(func).binv;
      end
      if (step_c) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {slice_res, res_sh[WIDTH-1:1]};
        carry  <= slice_cout;
        cnt    <= cnt + CW'(1);
        if (last_c) carry_msb <= carry;
      end
      if (finish_c) begin
        result   <= fin_res_c;
        zero     <= (fin_res_c == '0);
        cout     <= ctl.arith & carry;
        overflow <= ctl.arith & ovf_c;
      end
    end
  end

endmodule
